pgm_rom_loader: RTL and testbench

//  Sits between hps_io's ioctl download port and the PGM core's DDRAM write path.

---
 rtl/pgm_rom_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_pgm_rom_loader.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_rom_loader.sv
`timescale 1ns / 1ps
// Packs 16-bit HPS ioctl download words into 64-bit DDRAM beats with byte enables,
// issues single-beat writes, back-pressures the HPS and flags the end of a load.
module pgm_rom_loader #(
    parameter logic [28:0] DDR_BASE     = 29'h0600_0000,
    parameter int unsigned REGION_SHIFT = 21,
    parameter int unsigned NUM_REGIONS  = 4
) (
    input  logic        fixed_50m_clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    input  logic        ddram_busy,
    output logic        load_done,
    output logic        overflow,
    output logic [23:0] word_count
);

    localparam int unsigned AW  = 29;
    localparam int unsigned DW  = 64;
    localparam int unsigned BW  = 8;
    localparam int unsigned WCW = 24;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    function automatic logic idx_ok(input logic [7:0] idx);
        return 32'(idx) < NUM_REGIONS;
    endfunction

    logic [1:0]     state_q, state_d;
    logic           dl_q;
    logic           buf_valid_q, buf_valid_d;
    logic [AW-1:0]  buf_addr_q, buf_addr_d;
    logic [DW-1:0]  buf_din_q, buf_din_d;
    logic [BW-1:0]  buf_be_q, buf_be_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  din_q, din_d;
    logic [BW-1:0]  be_q, be_d;
    logic           final_q, final_d;
    logic           skid_valid_q, skid_valid_d;
    logic [25:0]    skid_addr_q, skid_addr_d;
    logic [15:0]    skid_data_q, skid_data_d;
    logic [7:0]     skid_idx_q, skid_idx_d;
    logic           load_done_q, load_done_d;
    logic           overflow_q, overflow_d;
    logic [WCW-1:0] wcount_q, wcount_d;

    logic           new_ok;
    logic           w_valid;
    logic [7:0]     w_idx;
    logic [25:0]    w_addr;
    logic [15:0]    w_data;
    logic [1:0]     w_lane;
    logic [AW-1:0]  w_waddr;
    logic [DW-1:0]  f_din, m_din;
    logic [BW-1:0]  f_be, m_be;
    logic           flush_now;

    // Byte addresses are always even, so bit 0 carries no information.
    logic unused_addr_bit;
    assign unused_addr_bit = ioctl_addr[0];

    always_comb begin
        state_d      = state_q;
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_din_d    = buf_din_q;
        buf_be_d     = buf_be_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;
        be_d         = be_q;
        final_d      = final_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        skid_idx_d   = skid_idx_q;
        load_done_d  = 1'b0;
        overflow_d   = overflow_q;
        wcount_d     = wcount_q;
        flush_now    = 1'b0;

        // A parked skid word is replayed ahead of any new HPS write.
        new_ok  = ioctl_wr && idx_ok(ioctl_index);
        w_valid = skid_valid_q || new_ok;
        w_idx   = skid_valid_q ? skid_idx_q  : ioctl_index;
        w_addr  = skid_valid_q ? skid_addr_q : ioctl_addr[26:1];
        w_data  = skid_valid_q ? skid_data_q : ioctl_dout;
        w_lane  = w_addr[1:0];
        w_waddr = DDR_BASE + (AW'(w_idx) << REGION_SHIFT) + AW'(w_addr[25:2]);

        f_din = '0;
        f_din[{w_lane, 4'b0000} +: 16] = w_data;
        f_be = '0;
        f_be[{w_lane, 1'b0} +: 2] = 2'b11;
        m_din = buf_valid_q ? buf_din_q : '0;
        m_din[{w_lane, 4'b0000} +: 16] = w_data;
        m_be = buf_valid_q ? buf_be_q : '0;
        m_be[{w_lane, 1'b0} +: 2] = 2'b11;

        case (state_q)
            S_IDLE: begin
                if (ioctl_download && !dl_q) begin
                    state_d    = S_FILL;
                    wcount_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            S_FILL: begin
                skid_valid_d = 1'b0;
                if (skid_valid_q && new_ok) begin
                    overflow_d = 1'b1;
                end
                if (w_valid) begin
                    if (buf_valid_q && (w_waddr != buf_addr_q)) begin
                        addr_d      = buf_addr_q;
                        din_d       = buf_din_q;
                        be_d        = buf_be_q;
                        buf_addr_d  = w_waddr;
                        buf_din_d   = f_din;
                        buf_be_d    = f_be;
                        buf_valid_d = 1'b1;
                        flush_now   = 1'b1;
                    end else if (w_lane == 2'd3) begin
                        addr_d      = w_waddr;
                        din_d       = m_din;
                        be_d        = m_be;
                        buf_valid_d = 1'b0;
                        flush_now   = 1'b1;
                    end else begin
                        buf_addr_d  = w_waddr;
                        buf_din_d   = m_din;
                        buf_be_d    = m_be;
                        buf_valid_d = 1'b1;
                    end
                end
                // End of download: the write of this cycle is handled before the final flush.
                if (flush_now) begin
                    we_d    = 1'b1;
                    state_d = S_FLUSH;
                    final_d = !ioctl_download && !buf_valid_d;
                end else if (!ioctl_download) begin
                    if (buf_valid_d) begin
                        addr_d      = buf_addr_d;
                        din_d       = buf_din_d;
                        be_d        = buf_be_d;
                        buf_valid_d = 1'b0;
                        we_d        = 1'b1;
                        state_d     = S_FLUSH;
                        final_d     = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (new_ok) begin
                    if (skid_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_addr_d  = ioctl_addr[26:1];
                        skid_data_d  = ioctl_dout;
                        skid_idx_d   = ioctl_index;
                    end
                end
                if (we_q && !ddram_busy) begin
                    we_d     = 1'b0;
                    wcount_d = wcount_q + WCW'(1);
                    final_d  = 1'b0;
                    if (final_q && !buf_valid_q && !skid_valid_d) begin
                        state_d     = S_IDLE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge fixed_50m_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_din_q    <= '0;
            buf_be_q     <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            be_q         <= '0;
            final_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            skid_idx_q   <= '0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wcount_q     <= '0;
        end else begin
            state_q      <= state_d;
            dl_q         <= ioctl_download;
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_din_q    <= buf_din_d;
            buf_be_q     <= buf_be_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            be_q         <= be_d;
            final_q      <= final_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            skid_idx_q   <= skid_idx_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            wcount_q     <= wcount_d;
        end
    end

    assign ioctl_wait = (state_q == S_FLUSH) || skid_valid_q;
    assign ddram_we   = we_q;
    assign ddram_addr = addr_q;
    assign ddram_din  = din_q;
    assign ddram_be   = be_q;
    assign load_done  = load_done_q;
    assign overflow   = overflow_q;
    assign word_count = wcount_q;

endmodule

// File: tb/tb_pgm_rom_loader.sv
`timescale 1ns / 1ps
// Bench for pgm_rom_loader: directed scenarios plus randomized downloads scored
// against a beat-level packing model.
module tb_pgm_rom_loader;

    typedef struct packed {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  b;
    } beat_t;

    localparam logic [28:0] BASE = 29'h0600_0000;
    localparam int          NREG = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic        ddram_busy;
    logic        load_done;
    logic        overflow;
    logic [23:0] word_count;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    ld_cnt = 0;
    int    last_ld_cyc = 0;
    int    last_acc_cyc = 0;
    bit    rand_busy = 1'b0;
    logic  busy_force = 1'b0;
    beat_t got_q[$];

    pgm_rom_loader dut (
        .fixed_50m_clk (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .ddram_we      (ddram_we),
        .ddram_addr    (ddram_addr),
        .ddram_din     (ddram_din),
        .ddram_be      (ddram_be),
        .ddram_busy    (ddram_busy),
        .load_done     (load_done),
        .overflow      (overflow),
        .word_count    (word_count)
    );

    initial forever #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DDRAM side: waitrequest either forced by the scenario or random.
    initial begin
        ddram_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ddram_busy = rand_busy ? 1'($urandom_range(0, 1)) : busy_force;
        end
    end

    // Observe accepted beats and load_done pulses mid-cycle.
    always @(negedge clk) begin
        if (ddram_we === 1'b1 && ddram_busy === 1'b0) begin
            got_q.push_back(beat_t'({ddram_addr, ddram_din, ddram_be}));
            last_acc_cyc = cyc;
        end
        if (load_done === 1'b1) begin
            ld_cnt++;
            last_ld_cyc = cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        ld_cnt = 0;
    endtask

    task automatic begin_dl();
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick(1);
    endtask

    task automatic wr_raw(input logic [26:0] a, input logic [15:0] d, input logic [7:0] idx);
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_index = idx;
        ioctl_wr    = 1'b1;
        tick(1);
        ioctl_wr    = 1'b0;
    endtask

    task automatic wr(input logic [26:0] a, input logic [15:0] d, input logic [7:0] idx);
        int t;
        t = 0;
        while (ioctl_wait === 1'b1 && t < 1000) begin
            tick(1);
            t++;
        end
        if (t >= 1000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timeout: ioctl_wait got %b for 1000 cycles, required release", ioctl_wait);
        end
        wr_raw(a, d, idx);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (ld_cnt == 0 && t < 500) begin
            tick(1);
            t++;
        end
        if (ld_cnt == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL load_done_timeout: got 0 pulses, required 1");
        end
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        n_cmp++;
        if ({ddram_we, ioctl_wait, load_done, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000", {ddram_we, ioctl_wait, load_done, overflow});
        end
        n_cmp++;
        if ({ddram_addr, ddram_din, ddram_be} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h/%h, required zeros", ddram_addr, ddram_din, ddram_be);
        end
        n_cmp++;
        if (word_count !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", word_count);
        end
    endtask

    task automatic test_full_beat();
        beat_t e;
        clear_obs();
        begin_dl();
        wr(27'h0, 16'h1111, 8'd0);
        wr(27'h2, 16'h2222, 8'd0);
        wr(27'h4, 16'h3333, 8'd0);
        wr(27'h6, 16'h4444, 8'd0);
        n_cmp++;
        if (ddram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL full_latency: we got %b one cycle after lane 3 write, required 1", ddram_we);
        end
        tick(3);
        e = {BASE, 64'h4444_3333_2222_1111, 8'hFF};
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            n_fail++;
            $display("FAIL full_beat: got %0d beats first %h, required 1 beat %h", got_q.size(), got_q[0], e);
        end
        n_cmp++;
        if (word_count !== 24'd1) begin
            n_fail++;
            $display("FAIL full_count: got %0d, required 1", word_count);
        end
        end_dl();
        wait_done();
        n_cmp++;
        if (ld_cnt !== 1 || got_q.size() !== 1) begin
            n_fail++;
            $display("FAIL full_done: got %0d pulses %0d beats, required 1 pulse 1 beat", ld_cnt, got_q.size());
        end
    endtask

    task automatic test_partial_fall();
        beat_t e;
        clear_obs();
        begin_dl();
        wr(27'h10, 16'haaaa, 8'd1);
        wr(27'h12, 16'hbbbb, 8'd1);
        end_dl();
        wait_done();
        e = {29'h0620_0002, 64'h0000_0000_bbbb_aaaa, 8'h0F};
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== e) begin
            n_fail++;
            $display("FAIL partial_beat: got %0d beats first %h, required 1 beat %h", got_q.size(), got_q[0], e);
        end
        n_cmp++;
        if (last_ld_cyc - last_acc_cyc !== 1 || ld_cnt !== 1) begin
            n_fail++;
            $display("FAIL partial_done: got delay %0d pulses %0d, required delay 1 pulses 1",
                     last_ld_cyc - last_acc_cyc, ld_cnt);
        end
        n_cmp++;
        if (word_count !== 24'd1) begin
            n_fail++;
            $display("FAIL partial_count: got %0d, required 1", word_count);
        end
    endtask

    task automatic test_nonseq();
        beat_t e0;
        beat_t e1;
        clear_obs();
        begin_dl();
        wr(27'h0, 16'h1234, 8'd0);
        wr(27'h40, 16'h5678, 8'd0);
        end_dl();
        wait_done();
        e0 = {BASE, 64'h0000_0000_0000_1234, 8'h03};
        e1 = {BASE + 29'd8, 64'h0000_0000_0000_5678, 8'h03};
        n_cmp++;
        if (got_q.size() !== 2 || got_q[0] !== e0 || got_q[1] !== e1) begin
            n_fail++;
            $display("FAIL nonseq_beats: got %0d beats %h %h, required %h %h", got_q.size(), got_q[0], got_q[1], e0, e1);
        end
        n_cmp++;
        if (word_count !== 24'd2) begin
            n_fail++;
            $display("FAIL nonseq_count: got %0d, required 2", word_count);
        end
    endtask

    task automatic test_busy_skid();
        logic [28:0] a0;
        logic [63:0] d0;
        beat_t e0;
        beat_t e1;
        clear_obs();
        busy_force = 1'b1;
        tick(1);
        begin_dl();
        for (int i = 0; i < 4; i++) wr(27'(27'h100 + 27'(i * 2)), 16'(16'h0a01 + 16'(i)), 8'd0);
        a0 = ddram_addr;
        d0 = ddram_din;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                ioctl_addr = 27'h200; ioctl_dout = 16'h5555; ioctl_index = 8'd0; ioctl_wr = 1'b1;
            end
            if (i == 6) begin
                ioctl_addr = 27'h208; ioctl_dout = 16'h6666; ioctl_index = 8'd0; ioctl_wr = 1'b1;
            end
            tick(1);
            ioctl_wr = 1'b0;
            n_cmp++;
            if (ddram_we !== 1'b1 || ioctl_wait !== 1'b1 || ddram_addr !== a0 || ddram_din !== d0) begin
                n_fail++;
                $display("FAIL busy_hold[%0d]: got we %b wait %b addr %h din %h, required 1 1 %h %h",
                         i, ddram_we, ioctl_wait, ddram_addr, ddram_din, a0, d0);
            end
            if (i == 5) begin
                n_cmp++;
                if (overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL skid_first: overflow got %b, required 0", overflow);
                end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_overflow: got %b, required 1", overflow);
        end
        busy_force = 1'b0;
        tick(5);
        end_dl();
        wait_done();
        e0 = {BASE + 29'h20, 64'h0a04_0a03_0a02_0a01, 8'hFF};
        e1 = {BASE + 29'h40, 64'h0000_0000_0000_5555, 8'h03};
        n_cmp++;
        if (got_q.size() !== 2 || got_q[0] !== e0 || got_q[1] !== e1) begin
            n_fail++;
            $display("FAIL skid_beats: got %0d beats %h %h, required %h %h", got_q.size(), got_q[0], got_q[1], e0, e1);
        end
        n_cmp++;
        if (overflow !== 1'b1 || word_count !== 24'd2) begin
            n_fail++;
            $display("FAIL skid_final: got ovf %b count %0d, required 1 2", overflow, word_count);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        busy_force = 1'b0;
        tick(1);
        begin_dl();
        for (int i = 0; i < 4; i++) wr(27'(i * 2), 16'(16'h0100 + 16'(i)), 8'd0);
        tick(3);
        busy_force = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) wr(27'(27'h8 + 27'(i * 2)), 16'(16'h0200 + 16'(i)), 8'd0);
        tick(2);
        n_cmp++;
        if (ddram_we !== 1'b1 || word_count !== 24'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: got we %b count %0d, required 1 1", ddram_we, word_count);
        end
        reset = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        reset = 1'b0;
        n_cmp++;
        if (ddram_we !== 1'b0 || ioctl_wait !== 1'b0 || word_count !== 24'd0) begin
            n_fail++;
            $display("FAIL rmid_post: got we %b wait %b count %0d, required 0 0 0", ddram_we, ioctl_wait, word_count);
        end
        busy_force = 1'b0;
        wr_raw(27'h6, 16'hbeef, 8'd0);
        tick(3);
        n_cmp++;
        if (got_q.size() !== 1 || ddram_we !== 1'b0 || ld_cnt !== 0) begin
            n_fail++;
            $display("FAIL rmid_idle: got %0d beats we %b pulses %0d, required 1 0 0", got_q.size(), ddram_we, ld_cnt);
        end
    endtask

    task automatic test_bad_index();
        clear_obs();
        begin_dl();
        for (int i = 0; i < 4; i++) begin
            wr_raw(27'(i * 2), 16'(16'h7700 + 16'(i)), 8'd7);
            n_cmp++;
            if (ioctl_wait !== 1'b0 || ddram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL badidx_quiet[%0d]: got wait %b we %b, required 0 0", i, ioctl_wait, ddram_we);
            end
        end
        end_dl();
        wait_done();
        n_cmp++;
        if (got_q.size() !== 0 || word_count !== 24'd0 || ld_cnt !== 1) begin
            n_fail++;
            $display("FAIL badidx_end: got %0d beats count %0d pulses %0d, required 0 0 1",
                     got_q.size(), word_count, ld_cnt);
        end
    endtask

    task automatic test_random();
        logic [26:0] wa[$];
        logic [15:0] wd[$];
        logic [7:0]  wi[$];
        beat_t       exp_q[$];
        beat_t       cur;
        bit          open;
        logic [26:0] p;
        logic [7:0]  di;
        int          n;
        for (int dl = 0; dl < 5; dl++) begin
            clear_obs();
            wa.delete(); wd.delete(); wi.delete(); exp_q.delete();
            rand_busy = 1'b1;
            begin_dl();
            n  = 24 + int'($urandom_range(0, 15));
            p  = 27'($urandom) & 27'h7FF_FFFE;
            di = 8'($urandom_range(0, NREG - 1));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) p = 27'($urandom) & 27'h7FF_FFFE;
                wa.push_back(p);
                wd.push_back(16'($urandom));
                wi.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : di);
                wr(wa[k], wd[k], wi[k]);
                p = p + 27'd2;
            end
            end_dl();
            wait_done();
            rand_busy = 1'b0;
            // Expected beats: a word opens a new beat when its DDRAM word differs from
            // the open one; lane 3 closes a beat it was merged into.
            open = 1'b0;
            cur  = '0;
            for (int k = 0; k < wa.size(); k++) begin
                logic [28:0] waddr;
                int          lane;
                if (int'(wi[k]) >= NREG) continue;
                waddr = BASE + (29'(wi[k]) << 21) + 29'(wa[k] >> 3);
                lane  = int'(wa[k][2:1]);
                if (open && waddr != cur.a) begin
                    exp_q.push_back(cur);
                    cur = '0;
                    cur.a = waddr;
                    cur.d[lane * 16 +: 16] = wd[k];
                    cur.b[lane * 2 +: 2] = 2'b11;
                end else begin
                    if (!open) begin
                        cur = '0;
                        cur.a = waddr;
                    end
                    cur.d[lane * 16 +: 16] = wd[k];
                    cur.b[lane * 2 +: 2] = 2'b11;
                    open = 1'b1;
                    if (lane == 3) begin
                        exp_q.push_back(cur);
                        open = 1'b0;
                    end
                end
            end
            if (open) exp_q.push_back(cur);
            n_cmp++;
            if (got_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_nbeats: got %0d, required %0d", dl, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                n_cmp++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h, required %h", dl, k, got_q[k], exp_q[k]);
                end
            end
            n_cmp++;
            if (word_count !== 24'(exp_q.size()) || overflow !== 1'b0 || ld_cnt !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_status: got count %0d ovf %b pulses %0d, required %0d 0 1",
                         dl, word_count, overflow, ld_cnt, exp_q.size());
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        test_reset();
        test_full_beat();
        test_partial_fall();
        test_nonseq();
        test_busy_skid();
        test_reset_mid();
        test_bad_index();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
